rxuart: RTL and testbench
=========================

# rxuart

Asynchronous serial receiver, 8N1, LSB first. Sits directly downstream of the transmit path: consumes the `o_uart_tx` line driven by `txuart` (loopback on the board, or an external host on the RX pin) and turns each received frame into a parallel byte with a one-cycle strobe. It oversamples with the system clock at a fixed, parameterised baud divisor. It validates the start and stop bits and reports framing errors.

## Interface
- `CLKS_PER_BAUD`, default 868: i_clk cycles per bit (100 MHz / 115200). Legal range 4..65535.
- `i_clk` input 1: system clock. All logic is on the rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset. Deassertion is synchronous to i_clk externally.
- `i_uart_rx` input 1: serial line, idle high. Asynchronous to i_clk.
- `o_data` output 8: last received byte. Holds until the next frame completes.
- `o_valid` output 1: one-cycle strobe, o_data holds a good byte.
- `o_frame_err` output 1: one-cycle strobe, stop bit sampled low.
- `o_busy` output 1: high while a frame is being received (any state other than IDLE).

## Operation
- Synchronizer: a 2-FF chain on i_uart_rx produces rx_s. Both FFs reset to 1.
- Baud counter: 16 bits, down-counting. "Tick" means counter == 0 in a non-IDLE state. On each tick the counter reloads with CLKS_PER_BAUD-1.
- Bit index: 3 bits, 0..7.
- Shift register: 8 bits. Sampled bits shift in at the MSB, so bit 0 ends at LSB after 8 shifts.
- FSM states:
  - IDLE
    - rx_s==0: load counter with CLKS_PER_BAUD/2-1 (integer divide), then go to START.
    - Otherwise stay.
  - START (on tick)
    - rx_s==0: index=0, go to DATA.
    - rx_s==1: glitch/false start. Return to IDLE with no strobe.
  - DATA (on tick)
    - Shift in rx_s.
    - If index==7, go to STOP.
    - Otherwise index++.
  - STOP (on tick)
    - rx_s==1: o_data <= shift register, o_valid=1, go to IDLE.
    - rx_s==0: o_data <= shift register, o_frame_err=1, go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. Prevents a held-low line (break) from being read as a stream of 0x00 frames.
- o_valid and o_frame_err are never high together. There is no consumer handshake: a downstream stage must capture o_data on the o_valid cycle.
- Reset values:
  - o_data = 8'h00, o_valid = 0, o_frame_err = 0, o_busy = 0.
  - FSM in IDLE, counter 0, index 0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately, with no strobe. After release, a line still low puts the FSM in START on a fresh edge. That is accepted behaviour; the stop check then flags it via o_frame_err/BREAK.

## Timing
- Let t0 be the first i_clk edge at which the sync FF1 captures i_uart_rx low.
- IDLE→START happens at edge t0+2. Let S = t0+2+CLKS_PER_BAUD/2.
- Sample points:
  - Start bit: edge S.
  - Data bit n (n=0..7): edge S+(n+1)·CLKS_PER_BAUD.
  - Stop bit: edge S+9·CLKS_PER_BAUD.
- o_valid / o_frame_err are high for exactly the one cycle following the stop-sample edge.
- o_busy is high from edge t0+2 through the stop-sample edge. It stays high while in BREAK.
- Back-to-back frames: a new start edge is accepted the cycle after returning to IDLE. That is half a bit before the nominal stop end, which gives tolerance of about ±4.5% total baud mismatch.
- Sampling is single-point at mid-bit. There is no majority vote.

## Test plan
- Reset: hold i_rst_n=0 with the line toggling. Required: all outputs at reset values and o_busy=0. After release, an idle-high line gives no strobes for 20·CLKS_PER_BAUD.
- Back-to-back bytes: 0x48 then 0x65 at exact baud, no idle gap, CLKS_PER_BAUD=868. Required:
  - o_valid pulses twice, with o_data=0x48 then 0x65.
  - Each pulse lands on the cycle after edge t0+2+434+9·868 (t0 per frame).
  - o_frame_err never asserted.
- Glitch: a low pulse of CLKS_PER_BAUD/2-4 cycles on an idle line. Required: return to IDLE, no strobe, o_busy deasserts after the start sample.
- Framing error: send 0xA5 with the stop bit low, then hold the line low 3 bit-times, then high. Required:
  - o_frame_err pulses once, with o_data=0xA5.
  - No o_valid, no further strobes during the low hold.
  - A following 0x3C frame is received with o_valid.
- Reset mid-frame: assert i_rst_n low during data bit 4 of 0x5A for 10 cycles, with the line idle afterward. Required: no strobe, o_data=0x00, and a subsequent 0x81 received correctly.
- Loopback with txuart driving i_uart_rx through the bytes 0x00, 0xFF, 0x55, 0xAA, with the same CLKS_PER_BAUD. Required: bytes received in order with no framing errors.

Source files
------------

// File: rtl/rxuart_if.sv
// Parallel side of the 8N1 receiver plus the serial line it listens to.
// master = receiver (drives the byte/strobes), slave = line driver / byte consumer.
interface rxuart_if;
    logic       uart_rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  uart_rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output uart_rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/rxuart.sv
// 8N1 LSB-first serial receiver, single mid-bit sample at a fixed baud divisor.
// Reports each frame as a one-cycle o_valid or o_frame_err strobe.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | line idle, waiting for a falling edge on the synced line
// START   | half a bit in, confirming the start bit is still low
// DATA    | sampling the 8 data bits, one per baud tick
// STOP    | sampling the stop bit, strobe valid or frame error
// BREAK   | stop was low, wait for the line to return high
module rxuart #(
    parameter int CLKS_PER_BAUD = 868
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    rxuart_if.master io_rx
);
    localparam logic [15:0] C_FULL = 16'(CLKS_PER_BAUD - 1);
    localparam logic [15:0] C_HALF = 16'(CLKS_PER_BAUD / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;

    logic        w_tick;
    logic        w_idx_clr;
    logic        w_shift;
    logic        w_done_ok;
    logic        w_done_err;
    logic        w_busy;

    assign w_tick = (r_state != S_IDLE) && (r_cnt == 16'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= io_rx.uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (!r_rx_s) w_state_nxt = S_START;
            S_START: if (w_tick) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && (r_idx == 3'd7)) w_state_nxt = S_STOP;
            S_STOP:  if (w_tick) w_state_nxt = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (r_rx_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_idx_clr  = (r_state == S_START) && w_tick;
        w_shift    = (r_state == S_DATA) && w_tick;
        w_done_ok  = (r_state == S_STOP) && w_tick && r_rx_s;
        w_done_err = (r_state == S_STOP) && w_tick && !r_rx_s;
        w_busy     = (r_state != S_IDLE);
    end

    // First reload is half a bit so every later tick lands mid-bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 16'd0;
        end else if (r_state == S_IDLE) begin
            if (!r_rx_s) r_cnt <= C_HALF;
        end else if (w_tick) begin
            r_cnt <= C_FULL;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_idx_clr) begin
                r_idx <= 3'd0;
            end else if (w_shift) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_shift) r_shift <= {r_rx_s, r_shift[7:1]};
            if (w_done_ok || w_done_err) r_data <= r_shift;
            r_valid     <= w_done_ok;
            r_frame_err <= w_done_err;
        end
    end

    assign io_rx.data      = r_data;
    assign io_rx.valid     = r_valid;
    assign io_rx.frame_err = r_frame_err;
    assign io_rx.busy      = w_busy;
endmodule

// File: tb/tb_rxuart.sv
// Bench for rxuart: frames driven bit-accurately, expected bytes queued at frame
// start and matched (data, strobe kind, strobe cycle) when the receiver strobes.
module tb_rxuart;
    localparam int CPB  = 868;
    localparam int HALF = CPB / 2;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         at;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   n_valid  = 0;
    int   n_ferr   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    rxuart_if bus ();

    rxuart #(.CLKS_PER_BAUD(CPB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_rx   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (bus.valid || bus.frame_err)) begin
            if (bus.valid) n_valid++;
            if (bus.frame_err) n_ferr++;
            checks++;
            if (bus.valid && bus.frame_err) begin
                failures++;
                $display("FAIL strobe_overlap: valid=1 frame_err=1, required at most one high");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: data=%02h valid=%0b frame_err=%0b cycle=%0d, required no strobe",
                         bus.data, bus.valid, bus.frame_err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (bus.data !== mon_e.data) begin
                    failures++;
                    $display("FAIL rx_data: got %02h required %02h", bus.data, mon_e.data);
                end
                checks++;
                if (bus.frame_err !== mon_e.ferr) begin
                    failures++;
                    $display("FAIL strobe_kind: frame_err=%0b required %0b", bus.frame_err, mon_e.ferr);
                end
                if (mon_e.at != 0) begin
                    checks++;
                    if (cyc != mon_e.at) begin
                        failures++;
                        $display("FAIL strobe_cycle: got cycle %0d required %0d", cyc, mon_e.at);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stands in for txuart: one 8N1 frame, entered and left on a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
        e.at   = cyc + 1 + 2 + HALF + 9 * CPB;
        exp_q.push_back(e);
        bus.uart_rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = d[i];
            wait_cycles(CPB);
        end
        bus.uart_rx = stop;
        wait_cycles(CPB);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        int v0, f0;
        rst_n = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                bus.uart_rx = ~bus.uart_rx;
            end
            checks++;
            if (bus.data !== 8'h00) begin failures++; $display("FAIL reset_data: got %02h required 00", bus.data); end
            checks++;
            if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b required 0", bus.valid); end
            checks++;
            if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %0b required 0", bus.frame_err); end
            checks++;
            if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", bus.busy); end
        end
        @(negedge clk);
        bus.uart_rx = 1'b1;
        rst_n = 1'b1;
        v0 = n_valid;
        f0 = n_ferr;
        wait_cycles(20 * CPB);
        checks++;
        if (n_valid != v0 || n_ferr != f0) begin
            failures++;
            $display("FAIL reset_idle_strobes: got %0d strobes required 0", (n_valid - v0) + (n_ferr - f0));
        end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %0b required 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h48, 1'b1);
        send_frame(8'h65, 1'b1);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing: %0d frames outstanding required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (n_valid - v0 != 2) begin failures++; $display("FAIL b2b_valid_count: got %0d required 2", n_valid - v0); end
        checks++;
        if (n_ferr != f0) begin failures++; $display("FAIL b2b_frame_err: got %0d required 0", n_ferr - f0); end
    endtask

    task automatic test_glitch();
        int v0, f0, t0;
        v0 = n_valid;
        f0 = n_ferr;
        t0 = cyc + 1;
        bus.uart_rx = 1'b0;
        wait_cycles(HALF - 4);
        bus.uart_rx = 1'b1;
        for (int i = 0; i < 2 * CPB && cyc < t0 + 2 + HALF - 1; i++) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_before: got %0b required 1 at cycle %0d", bus.busy, cyc); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_after: got %0b required 0 at cycle %0d", bus.busy, cyc); end
        wait_cycles(CPB);
        checks++;
        if (n_valid != v0 || n_ferr != f0) begin
            failures++;
            $display("FAIL glitch_strobes: got %0d required 0", (n_valid - v0) + (n_ferr - f0));
        end
    endtask

    task automatic test_frame_error();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'hA5, 1'b0);
        wait_cycles(3 * CPB);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL break_busy: got %0b required 1", bus.busy); end
        bus.uart_rx = 1'b1;
        wait_cycles(CPB);
        checks++;
        if (n_ferr - f0 != 1) begin failures++; $display("FAIL ferr_count: got %0d required 1", n_ferr - f0); end
        checks++;
        if (n_valid != v0) begin failures++; $display("FAIL ferr_valid: got %0d required 0", n_valid - v0); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL break_exit_busy: got %0b required 0", bus.busy); end
        send_frame(8'h3C, 1'b1);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL ferr_missing: %0d frames outstanding required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (n_valid - v0 != 1) begin failures++; $display("FAIL ferr_next_valid: got %0d required 1", n_valid - v0); end
    endtask

    task automatic test_reset_mid();
        int v0, f0;
        logic [7:0] d;
        d = 8'h5A;
        v0 = n_valid;
        f0 = n_ferr;
        bus.uart_rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.uart_rx = d[i];
            wait_cycles(CPB);
        end
        bus.uart_rx = d[4];
        wait_cycles(HALF);
        rst_n = 1'b0;
        wait_cycles(10);
        checks++;
        if (bus.data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %02h required 00", bus.data); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b required 0", bus.busy); end
        bus.uart_rx = 1'b1;
        rst_n = 1'b1;
        wait_cycles(CPB);
        checks++;
        if (n_valid != v0 || n_ferr != f0) begin
            failures++;
            $display("FAIL midrst_strobes: got %0d required 0", (n_valid - v0) + (n_ferr - f0));
        end
        checks++;
        if (bus.data !== 8'h00) begin failures++; $display("FAIL midrst_data_after: got %02h required 00", bus.data); end
        send_frame(8'h81, 1'b1);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_missing: %0d frames outstanding required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (bus.data !== 8'h81) begin failures++; $display("FAIL midrst_next_data: got %02h required 81", bus.data); end
    endtask

    task automatic test_loopback();
        logic [7:0] lb [4];
        int v0, f0;
        lb = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        v0 = n_valid;
        f0 = n_ferr;
        for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b1);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL loop_missing: %0d frames outstanding required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (n_valid - v0 != 4) begin failures++; $display("FAIL loop_valid_count: got %0d required 4", n_valid - v0); end
        checks++;
        if (n_ferr != f0) begin failures++; $display("FAIL loop_frame_err: got %0d required 0", n_ferr - f0); end
    endtask

    initial begin
        #(10 * 150_000);
        $display("FAIL watchdog: simulation did not finish within 150000 cycles");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.uart_rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
